// File: rtl/min_pair_stream.sv
// Serial minimum/second-minimum tracker: buffers a frame of N samples, tracks
// the two smallest values and the first index of the smallest, then holds them.
module min_pair_stream #(
  parameter int N  = 16,
  parameter int W  = 4,
  parameter int IW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   min1,
  output logic [W-1:0]   min2,
  output logic [IW-1:0]  index_min1,
  output logic [W*N-1:0] frame
);

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [W-1:0]  ALL_ONES = '1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e                  state_q, state_d;
  logic [IW-1:0]           cnt_q, cnt_d;
  logic [W-1:0]            min1_q, min1_d;
  logic [W-1:0]            min2_q, min2_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [N-1:0][W-1:0]     frame_q, frame_d;

  logic accept;

  // Handshake flags come from state alone, so no input reaches them combinationally.
  assign in_ready   = (state_q == LOAD);
  assign out_valid  = (state_q == HOLD);
  assign accept     = in_valid && in_ready;

  assign min1       = min1_q;
  assign min2       = min2_q;
  assign index_min1 = idx_q;
  assign frame      = frame_q;

  always_comb begin
    // NOTE: every _d gets a default from its _q first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    min1_d  = min1_q;
    min2_d  = min2_q;
    idx_d   = idx_q;
    frame_d = frame_q;

    if (clr) begin
      // Abort wins over both handshakes; the buffered frame is left as is.
      state_d = LOAD;
      cnt_d   = '0;
      min1_d  = ALL_ONES;
      min2_d  = ALL_ONES;
      idx_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            frame_d[cnt_q] = in_data;
            // Ties with min1 fall through to the min2 path, keeping the first index.
            if (in_data < min1_q) begin
              min2_d = min1_q;
              min1_d = in_data;
              idx_d  = cnt_q;
            end else if (in_data < min2_q) begin
              min2_d = in_data;
            end
            cnt_d = cnt_q + IW'(1);
            if (cnt_q == LAST_IDX) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = LOAD;
            min1_d  = ALL_ONES;
            min2_d  = ALL_ONES;
            idx_d   = '0;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  // NOTE: the sample buffer is reset along with the control state because its
  // contents are visible on the frame port; a reset-less array would expose X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      min1_q  <= ALL_ONES;
      min2_q  <= ALL_ONES;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: doc/min_pair_stream.md
Name: min_pair_stream

Overview:
- Serial-input, sequential counterpart to the team's combinational 16-input minimum finder.
- Accepts a frame of N samples, one per handshake, into an internal sample buffer.
- Tracks the smallest value, the second-smallest value and the index of the smallest as samples arrive.
- Presents the results plus the buffered frame on a valid/ready output port for downstream Huffman-style pair selection.

Parameters:
- N, 16: samples per frame; must be a power of two, at least 2.
- W, 4: sample width in bits.
- IW, 4: index width; must equal log2(N).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous frame abort/restart
- in_valid  input  1  sample present
- in_ready  output  1  block accepts a sample
- in_data  input  W  sample value
- out_valid  output  1  results valid
- out_ready  input  1  downstream accepts results
- min1  output  W  smallest sample in the frame
- min2  output  W  second-smallest sample in the frame (multiset)
- index_min1  output  IW  position of the first occurrence of min1
- frame  output  W*N  buffered samples; sample k at bits [k*W +: W]

Behaviour:
- One clock domain. rst_n low asynchronously forces every register to its reset value; state, counters and outputs update only on rising clk edges.
- Reset values: state=LOAD, cnt=0, min1 and min2 all ones (2^W-1), index_min1=0, frame=0, out_valid=0, in_ready=1 (once out of reset).
- States:
  - LOAD: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- LOAD accept: a sample is accepted when in_valid && in_ready. Sample k is the k-th accepted sample, k=cnt.
- On each accept:
  - frame[k] <= in_data.
  - If in_data < min1 (strict): min2 <= min1, min1 <= in_data, index_min1 <= k.
  - Else if in_data < min2: min2 <= in_data.
  - Otherwise min1, min2 and index unchanged.
  - cnt <= cnt+1.
- Tie handling:
  - Equal to min1: goes to the min2 path, so duplicates of the minimum give min2 == min1.
  - The index stays at the first occurrence.
- Completing a frame: the accept with cnt==N-1 moves the FSM to HOLD. out_valid rises on the next cycle, so latency is one clock from the last accept. cnt wraps to 0.
- Outputs are live during LOAD and show the running values, but they are only meaningful while out_valid=1. In HOLD, all outputs are stable until the handshake completes.
- HOLD exit: out_valid && out_ready moves the FSM to LOAD on that edge and resets the trackers:
  - min1 and min2 return to all ones; index_min1 returns to 0; frame is retained.
  - in_ready=1 on the next cycle. There is no same-cycle accept during the HOLD→LOAD transition.
- out_valid must not drop without out_ready, and data must not change while out_valid=1 and out_ready=0.
- clr=1 in any state, sampled at the clock edge:
  - state=LOAD, cnt=0, trackers reset, out_valid=0.
  - Any concurrent in_valid is dropped; any pending result is discarded.
  - clr has priority over all handshakes.
- All-ones samples: a frame whose samples all equal 2^W-1 yields min1=min2=2^W-1 and index_min1=0, because strict < never fires.
- No combinational path from in_valid/out_ready to in_ready/out_valid; both are decoded from state only.

Test Plan:
- Frame, W=4 N=16: 2,3,1,2,5,6,9×10, one per cycle -> out_valid one cycle after the 16th accept; min1=1, min2=2, index_min1=2; frame[0]=2.
- Frame: 5,2,10,0,4,1,9×10, with in_valid toggling every other cycle -> min1=0, min2=1, index_min1=3; only valid cycles counted.
- Duplicate minimum: 1,4,2,1,2,12,9×10 -> min1=1, min2=1, index_min1=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid ignored. out_ready=1 -> next frame of all 15 gives min1=min2=15, index_min1=0.
- clr asserted after 7 accepts -> the next 16 samples form a fresh frame with results from those only. clr during HOLD -> out_valid=0 on the next cycle.
- rst_n pulsed low mid-frame, asynchronously between edges -> outputs go to reset values immediately; the first frame after release is correct.
